// File: rtl/lmac_pkg.sv
// Shared definitions for the LMAC TX arbitration path: widths, FSM states
// and the round-robin search helper.
package lmac_pkg;

    localparam int unsigned LMAC_DATA_W  = 256;
    localparam int unsigned LMAC_USEDW_W = 13;
    localparam int unsigned LMAC_MAX_REQ = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lmac_state_e;

    // First set bit of mask after 'last', wrapping modulo n; returns 'last' if mask is empty.
    function automatic logic [2:0] next_rr(
        input logic [LMAC_MAX_REQ-1:0] mask,
        input logic [2:0]              last,
        input int unsigned             n
    );
        logic        found;
        int unsigned idx;
        next_rr = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= LMAC_MAX_REQ; k++) begin
            idx = (32'(last) + k) % n;
            if (!found && (k <= n) && mask[idx[2:0]]) begin
                next_rr = idx[2:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/lmac_rr_pick.sv
// Combinational round-robin picker: index of the first requester after the
// last granted one, plus an any-request flag.
module lmac_rr_pick
    import lmac_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_last,
    output logic [2:0]         o_idx,
    output logic               o_any
);

    logic [LMAC_MAX_REQ-1:0] w_mask;

    always_comb begin
        w_mask              = '0;
        w_mask[NUM_REQ-1:0] = i_req;
        o_idx               = next_rr(w_mask, i_last, NUM_REQ);
        o_any               = |i_req;
    end

endmodule

// File: rtl/lmac_tx_arb.sv
// Packet-granular round-robin arbiter sharing the LMAC TX FIFO write port
// between NUM_REQ host queues, with occupancy throttling and completion stats.
module lmac_tx_arb
    import lmac_pkg::*;
#(
    parameter int unsigned              NUM_REQ   = 4,
    parameter int unsigned              DATA_W    = LMAC_DATA_W,
    parameter logic [LMAC_USEDW_W-1:0]  AF_THRESH = 13'd8000,
    parameter int unsigned              LEN_W     = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tx_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_eop,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_mac_wr,
    output logic [DATA_W-1:0]           tx_mac_data,
    input  logic                        tx_mac_full,
    input  logic [LMAC_USEDW_W-1:0]     tx_mac_usedw,
    output logic                        busy,
    output logic [2:0]                  grant_id,
    output logic                        pkt_done,
    output logic [LEN_W-1:0]            pkt_len
);

    lmac_state_e         r_state;
    lmac_state_e         w_state_nxt;
    logic [2:0]          r_grant_id;
    logic [2:0]          r_last_grant;
    logic [LEN_W-1:0]    r_count;
    logic                r_wr;
    logic [DATA_W-1:0]   r_data;
    logic                r_done;
    logic [LEN_W-1:0]    r_len;

    logic                w_stall;
    logic [2:0]          w_pick_idx;
    logic                w_pick_any;
    logic                w_grant;
    logic                w_accept;
    logic                w_sel_valid;
    logic                w_sel_eop;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]  w_ready;
    logic [LEN_W-1:0]    w_count_inc;

    assign w_stall     = tx_mac_full | (tx_mac_usedw >= AF_THRESH);
    assign w_count_inc = (&r_count) ? r_count : r_count + 1'b1;

    lmac_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // Mux the granted queue; ready depends only on state, grant and stall.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_data  = '0;
        w_ready     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == 3'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_eop   = req_eop[i];
                w_sel_data  = req_data[i*DATA_W +: DATA_W];
                w_ready[i]  = (r_state == ST_BUSY) & ~w_stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_en && !w_stall && w_pick_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_accept = w_sel_valid & ~w_stall;
                if (w_accept && w_sel_eop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_id   <= '0;
            r_last_grant <= 3'(NUM_REQ - 1);
            r_count      <= '0;
            r_wr         <= 1'b0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_len        <= '0;
        end else begin
            r_wr   <= w_accept;
            r_done <= w_accept & w_sel_eop;
            if (w_grant) begin
                r_grant_id <= w_pick_idx;
                r_count    <= '0;
            end
            if (w_accept) begin
                r_data  <= w_sel_data;
                r_count <= w_count_inc;
                if (w_sel_eop) begin
                    r_len        <= w_count_inc;
                    r_last_grant <= r_grant_id;
                end
            end
        end
    end

    assign req_ready   = w_ready;
    assign tx_mac_wr   = r_wr;
    assign tx_mac_data = r_data;
    assign busy        = (r_state == ST_BUSY);
    assign grant_id    = r_grant_id;
    assign pkt_done    = r_done;
    assign pkt_len     = r_len;

endmodule

// File: doc/lmac_tx_arb.md
# lmac_tx_arb

Packet-granular round-robin arbiter that shares the single LMAC TX path (tx_mac_wr / tx_mac_data / tx_mac_full / tx_mac_usedw) between NUM_REQ host transmit queues. It sits between the host DMA queues and the LMAC core TX FIFO. It never interleaves words of different packets, and it throttles on FIFO occupancy. It also reports per-packet completion (requester id, length in words) for the stats logic.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 256, data word width, matches tx_mac_data
- AF_THRESH, 13'd8000, tx_mac_usedw level at or above which no new word is accepted
- LEN_W, 10, width of the packet word counter

Ports:
- clk  in  1  core clock, same clock as the LMAC core
- reset  in  1  synchronous, active-high reset
- tx_en  in  1  transmit enable, from fmac_ctrl
- req_valid  in  NUM_REQ  per-queue word valid
- req_data  in  NUM_REQ*DATA_W  per-queue word; queue i occupies bits [i*DATA_W +: DATA_W]
- req_eop  in  NUM_REQ  last word of the packet
- req_ready  out  NUM_REQ  per-queue accept; one-hot or zero
- tx_mac_wr  out  1  write strobe to the LMAC TX FIFO
- tx_mac_data  out  DATA_W  write data to the LMAC TX FIFO
- tx_mac_full  in  1  LMAC TX FIFO full
- tx_mac_usedw  in  13  LMAC TX FIFO fill level
- busy  out  1  a packet is in flight
- grant_id  out  3  index of the current or last granted queue
- pkt_done  out  1  one-cycle pulse when an EOP word is written
- pkt_len  out  LEN_W  words in the completed packet; valid with pkt_done; saturates at all-ones

## Operation
- stall = tx_mac_full | (tx_mac_usedw >= AF_THRESH).
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Moves to BUSY when tx_en=1, stall=0 and any req_valid=1.
  - Grant goes to the first valid queue searching from last_grant+1 upward, modulo NUM_REQ.
  - grant_id is latched on entry to BUSY.
- BUSY:
  - req_ready[grant_id] = ~stall; all other req_ready bits are 0.
  - A word is accepted when req_valid & req_ready on the granted queue.
  - An accepted word with req_eop=1 sets last_grant=grant_id and returns the FSM to IDLE.
- tx_en falling mid-packet: the current packet completes normally; no new grant is issued until tx_en=1.
- Word counter:
  - Cleared on grant, incremented per accepted word.
  - On an EOP word, pkt_len = count+1, saturated.
- Reset mid-packet:
  - FSM goes to IDLE, last_grant = NUM_REQ-1 (so the first grant goes to queue 0), all outputs clear.
  - A truncated packet already in the LMAC FIFO is not repaired; the host resets the LMAC alongside.
- Reset values: req_ready=0, tx_mac_wr=0, tx_mac_data=0, busy=0, grant_id=0, pkt_done=0, pkt_len=0.

## Timing
- req_ready is combinational from state, grant_id and stall. No combinational path from req_valid to req_ready.
- Accepted word at cycle N gives tx_mac_wr=1 with that data at cycle N+1 (one register stage).
- pkt_done and pkt_len are asserted at cycle N+1, aligned with the EOP word's tx_mac_wr.
- Latency from request to grant:
  - Request in IDLE at cycle N: BUSY at N+1, first word accepted at N+1 at the earliest.
  - Between packets, at least one IDLE cycle (one bubble).
- Backpressure:
  - stall gates acceptance in the same cycle.
  - AF_THRESH headroom covers the one registered word in flight plus the LMAC usedw update latency.
  - tx_mac_wr never asserts while tx_mac_full was 1 in the previous cycle.
- Simultaneous events:
  - EOP accepted in the same cycle tx_en falls: normal completion, then IDLE.
  - All queues valid: strict rotation 0,1,2,3,0…
  - A single active queue is re-granted after each one-cycle bubble.

## Structure
- Shared package lmac_pkg holds:
  - constants LMAC_DATA_W=256 and LMAC_USEDW_W=13
  - the state enum for IDLE and BUSY
  - the function next_rr(mask, last) returning the index
- One natural sub-module, lmac_rr_pick: combinational round-robin priority picker, parameterised by NUM_REQ, inputs req mask and last index, outputs index and any.
- Everything else stays in lmac_tx_arb.

## Test plan
- Reset, then queue 0 sends a 3-word packet with usedw=0 → grant_id=0; tx_mac_wr high for 3 consecutive cycles starting 2 cycles after the request; pkt_done with pkt_len=3.
- All 4 queues continuously valid with 2-word packets → grant order 0,1,2,3,0; exactly one idle cycle between packets; no interleaving of words from different queues.
- usedw=8000 asserted mid-packet for 5 cycles → req_ready=0 and no tx_mac_wr for those cycles; the packet resumes without data loss or reorder.
- tx_en dropped after word 2 of a 6-word packet → all 6 words are written, then busy=0 and no new grant until tx_en=1.
- reset asserted on word 3 of queue 2's packet → next cycle all outputs are 0; after reset, queue 2 and queue 0 both valid → queue 0 granted first.
- 1100-word packet with LEN_W=10 → pkt_len=1023 (saturated); all 1100 words written.
